// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared PWM frame constants, decoder state type and helpers
// Exports: frame geometry (CLKS_PER_SLOT, SLOTS, PERIOD_CLKS), duty code width,
// decoder counter width/limits, generator-side widths, dec_state_e, sat_inc, high_to_duty.
package pwm_pkg;

    localparam int CLKS_PER_SLOT = 16;
    localparam int SLOTS         = 16;
    localparam int PERIOD_TOL    = 4;
    localparam int DUTY_W        = $clog2(SLOTS);
    localparam int PERIOD_CLKS   = CLKS_PER_SLOT * SLOTS;
    localparam int TIMEOUT       = PERIOD_CLKS + PERIOD_TOL;

    // Generator side: slot-phase and slot-index counter widths.
    localparam int SLOT_CNT_W    = $clog2(CLKS_PER_SLOT);
    localparam int SLOT_IDX_W    = $clog2(SLOTS);

    // Decoder counters cover twice a nominal period so an over-long period
    // is still measurable before they saturate.
    localparam int CNT_W = $clog2(2 * PERIOD_CLKS);

    localparam logic [CNT_W-1:0] PER_MIN     = CNT_W'(PERIOD_CLKS - PERIOD_TOL);
    localparam logic [CNT_W-1:0] PER_MAX     = CNT_W'(PERIOD_CLKS + PERIOD_TOL);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } dec_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // Round the high time to the nearest whole slot, clamped to the top code.
    function automatic logic [DUTY_W-1:0] high_to_duty(input logic [CNT_W-1:0] high);
        logic [CNT_W:0] rounded;
        rounded = {1'b0, high} + (CNT_W+1)'(CLKS_PER_SLOT / 2);
        rounded = rounded / (CNT_W+1)'(CLKS_PER_SLOT);
        if (rounded > (CNT_W+1)'(SLOTS - 1)) begin
            return DUTY_W'(SLOTS - 1);
        end
        return rounded[DUTY_W-1:0];
    endfunction

endpackage

// File: rtl/pwm_in_sync.sv
// rtl/pwm_in_sync.sv - pwm_in synchronizer, optional glitch filter, edge strobes
// Ports: clk, reset (sync, active-high), pwm_in (async);
//        level (clean line level), rise/fall (one-cycle strobes aligned with level).
// Macro PWM_GLITCH_FILTER_EN: adds a 3-sample filter, edge-to-strobe latency 3 -> 5.
module pwm_in_sync (
    input  logic clk,
    input  logic reset,
    input  logic pwm_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync1_q;
    logic sync2_q;
    logic level_d;
    logic level_q;
    logic rise_d;
    logic rise_q;
    logic fall_d;
    logic fall_q;

`ifdef PWM_GLITCH_FILTER_EN
    // Two older samples plus the current one: the level only moves once
    // three consecutive samples agree, so 1-2 cycle pulses never get through.
    logic [1:0] hist_d;
    logic [1:0] hist_q;

    always_comb begin
        hist_d  = {hist_q[0], sync2_q};
        level_d = level_q;
        if ((sync2_q == hist_q[0]) && (sync2_q == hist_q[1])) begin
            level_d = sync2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end
`else
    always_comb begin
        level_d = sync2_q;
    end
`endif

    // Strobes are computed from level_d so they land in the same cycle
    // the registered level changes.
    always_comb begin
        rise_d = level_d & ~level_q;
        fall_d = ~level_d & level_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= pwm_in;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/pwm_duty_decoder.sv
// rtl/pwm_duty_decoder.sv - recovers the duty code from an incoming PWM line
// Ports: clk_50M, reset (sync, active-high), pwm_in (async);
//        duty_cycle (last decoded code), duty_valid (pulse, code updated same cycle),
//        period_err (pulse, period out of tolerance), stuck_high (level, line high past timeout).
// Macro PWM_GLITCH_FILTER_EN: enables the input glitch filter in pwm_in_sync.
module pwm_duty_decoder
    import pwm_pkg::*;
(
    input  logic              clk_50M,
    input  logic              reset,
    input  logic              pwm_in,
    output logic [DUTY_W-1:0] duty_cycle,
    output logic              duty_valid,
    output logic              period_err,
    output logic              stuck_high
);

    logic line_level;
    logic line_rise;
    logic line_fall;

    pwm_in_sync u_in_sync (
        .clk    (clk_50M),
        .reset  (reset),
        .pwm_in (pwm_in),
        .level  (line_level),
        .rise   (line_rise),
        .fall   (line_fall)
    );

    dec_state_e        state_d;
    dec_state_e        state_q;
    logic [CNT_W-1:0]  high_cnt_d;
    logic [CNT_W-1:0]  high_cnt_q;
    logic [CNT_W-1:0]  per_cnt_d;
    logic [CNT_W-1:0]  per_cnt_q;
    logic [CNT_W-1:0]  to_cnt_d;
    logic [CNT_W-1:0]  to_cnt_q;
    logic [DUTY_W-1:0] duty_d;
    logic [DUTY_W-1:0] duty_q;
    logic              valid_d;
    logic              valid_q;
    logic              perr_d;
    logic              perr_q;
    logic              stuck_d;
    logic              stuck_q;

    logic [CNT_W-1:0]  per_meas;
    logic              per_ok;
    logic              timeout;

    always_comb begin
        state_d    = state_q;
        high_cnt_d = high_cnt_q;
        per_cnt_d  = per_cnt_q;
        to_cnt_d   = sat_inc(to_cnt_q);
        duty_d     = duty_q;
        valid_d    = 1'b0;
        perr_d     = 1'b0;
        stuck_d    = stuck_q;

        // per_cnt has not yet counted the rise cycle itself; include it so
        // the measurement equals the rise-to-rise distance.
        per_meas = sat_inc(per_cnt_q);
        per_ok   = (per_meas >= PER_MIN) && (per_meas <= PER_MAX);
        // Exact match: the counter saturates past this, so it fires once.
        timeout  = (to_cnt_q == TIMEOUT_CNT);

        if (line_fall) begin
            stuck_d = 1'b0;
        end

        // A rise takes priority over a coinciding timeout.
        if (line_rise) begin
            to_cnt_d   = '0;
            high_cnt_d = '0;
            per_cnt_d  = '0;
            state_d    = HIGH;
            if (state_q == LOW) begin
                if (per_ok) begin
                    duty_d  = high_to_duty(high_cnt_q);
                    valid_d = 1'b1;
                end else begin
                    perr_d = 1'b1;
                end
            end
        end else if (timeout) begin
            state_d = IDLE;
            if (line_level) begin
                stuck_d = 1'b1;
            end else begin
                duty_d  = '0;
                valid_d = 1'b1;
            end
        end else begin
            case (state_q)
                HIGH: begin
                    high_cnt_d = sat_inc(high_cnt_q);
                    per_cnt_d  = sat_inc(per_cnt_q);
                    if (line_fall) begin
                        state_d = LOW;
                    end
                end
                LOW: begin
                    per_cnt_d = sat_inc(per_cnt_q);
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            state_q    <= IDLE;
            high_cnt_q <= '0;
            per_cnt_q  <= '0;
            to_cnt_q   <= '0;
            duty_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            stuck_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            high_cnt_q <= high_cnt_d;
            per_cnt_q  <= per_cnt_d;
            to_cnt_q   <= to_cnt_d;
            duty_q     <= duty_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            stuck_q    <= stuck_d;
        end
    end

    assign duty_cycle = duty_q;
    assign duty_valid = valid_q;
    assign period_err = perr_q;
    assign stuck_high = stuck_q;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// tb/tb_pwm_duty_decoder.sv - self-checking bench for pwm_duty_decoder
module tb_pwm_duty_decoder;

    localparam int T_SLOT   = 16;
    localparam int T_SLOTS  = 16;
    localparam int T_PERIOD = 256;
    localparam int T_TOL    = 4;

    logic       clk_50M = 1'b0;
    logic       reset   = 1'b1;
    logic       pwm_in  = 1'b0;
    logic [3:0] duty_cycle;
    logic       duty_valid;
    logic       period_err;
    logic       stuck_high;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        bit v;
        bit e;
        int duty;
        int cyc;
    } ev_t;

    ev_t  ev_q[$];
    int   stray_changes  = 0;
    int   stuck_rise_cyc = -1;
    logic last_stuck     = 1'b0;
    logic [3:0] last_duty = 4'd0;
    logic reset_seen     = 1'b1;

    int fr_h[$];
    int fr_p[$];
    int glitch_at     = 0;
    int model_duty    = 0;
    int last_rise_cyc = 0;
    int rel_cyc       = 0;

    pwm_duty_decoder dut (
        .clk_50M    (clk_50M),
        .reset      (reset),
        .pwm_in     (pwm_in),
        .duty_cycle (duty_cycle),
        .duty_valid (duty_valid),
        .period_err (period_err),
        .stuck_high (stuck_high)
    );

    always #10 clk_50M = ~clk_50M;

    always @(posedge clk_50M) begin
        cyc        <= cyc + 1;
        reset_seen <= reset;
    end

    // Record every report and any duty change not announced by duty_valid.
    always @(negedge clk_50M) begin
        if (duty_valid === 1'b1 || period_err === 1'b1) begin
            ev_q.push_back(ev_t'{duty_valid, period_err, int'(duty_cycle), cyc});
        end
        if (!reset_seen && duty_cycle !== last_duty && duty_valid !== 1'b1) begin
            stray_changes <= stray_changes + 1;
        end
        last_duty <= duty_cycle;
        if (stuck_high === 1'b1 && last_stuck !== 1'b1) begin
            stuck_rise_cyc <= cyc;
        end
        last_stuck <= stuck_high;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic step(input logic v, input int n);
        if (v && !pwm_in) last_rise_cyc = cyc;
        pwm_in = v;
        repeat (n) begin
            @(posedge clk_50M);
            #1;
        end
    endtask

    task automatic do_reset(input logic line);
        @(posedge clk_50M);
        #1;
        reset  = 1'b1;
        pwm_in = line;
        repeat (3) begin
            @(posedge clk_50M);
            #1;
        end
        reset      = 1'b0;
        model_duty = 0;
        rel_cyc    = cyc;
    endtask

    // Plays fr_h/fr_p frames plus one closing rise and checks every report
    // against the period/high-time rules.
    task automatic play(input string name);
        int   first;
        int   stray_base;
        int   d;
        int   exp_err[$];
        int   exp_duty[$];
        ev_t  e;
        logic [1:0] want;
        first      = ev_q.size();
        stray_base = stray_changes;
        for (int i = 0; i < fr_h.size(); i++) begin
            if (glitch_at > 0) begin
                step(1'b1, glitch_at);
                step(1'b0, 2);
                step(1'b1, fr_h[i] - glitch_at - 2);
            end else begin
                step(1'b1, fr_h[i]);
            end
            step(1'b0, fr_p[i] - fr_h[i]);
            if (fr_p[i] >= T_PERIOD - T_TOL && fr_p[i] <= T_PERIOD + T_TOL) begin
                d = (fr_h[i] + T_SLOT / 2) / T_SLOT;
                if (d > T_SLOTS - 1) d = T_SLOTS - 1;
                model_duty = d;
                exp_err.push_back(0);
            end else begin
                exp_err.push_back(1);
            end
            exp_duty.push_back(model_duty);
        end
        step(1'b1, 10);

        checks++;
        if (ev_q.size() - first !== exp_err.size()) begin
            errors++;
            $display("FAIL %s count: got %0d reports, expected %0d", name, ev_q.size() - first, exp_err.size());
        end
        for (int i = 0; i < exp_err.size() && first + i < ev_q.size(); i++) begin
            e    = ev_q[first + i];
            want = (exp_err[i] != 0) ? 2'b01 : 2'b10;
            checks++;
            if ({e.v, e.e} !== want) begin
                errors++;
                $display("FAIL %s report %0d kind: got valid=%b err=%b, expected valid=%b err=%b",
                         name, i, e.v, e.e, want[1], want[0]);
            end
            checks++;
            if (e.duty !== exp_duty[i]) begin
                errors++;
                $display("FAIL %s report %0d duty: got %0d, expected %0d", name, i, e.duty, exp_duty[i]);
            end
            if (i > 0) begin
                checks++;
                if (e.cyc - ev_q[first + i - 1].cyc !== fr_p[i]) begin
                    errors++;
                    $display("FAIL %s report %0d spacing: got %0d cycles, expected %0d",
                             name, i, e.cyc - ev_q[first + i - 1].cyc, fr_p[i]);
                end
            end
        end
        checks++;
        if (stray_changes !== stray_base) begin
            errors++;
            $display("FAIL %s stray duty change: got %0d unannounced changes, expected 0", name, stray_changes - stray_base);
        end
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        @(negedge clk_50M);
        checks++;
        if (duty_cycle !== 4'd0) begin errors++; $display("FAIL reset duty_cycle: got %0d, expected 0", duty_cycle); end
        checks++;
        if (duty_valid !== 1'b0) begin errors++; $display("FAIL reset duty_valid: got %b, expected 0", duty_valid); end
        checks++;
        if (period_err !== 1'b0) begin errors++; $display("FAIL reset period_err: got %b, expected 0", period_err); end
        checks++;
        if (stuck_high !== 1'b0) begin errors++; $display("FAIL reset stuck_high: got %b, expected 0", stuck_high); end
    endtask

    task automatic test_timeout_low();
        int first;
        do_reset(1'b0);
        first = ev_q.size();
        step(1'b0, 300);
        checks++;
        if (ev_q.size() - first !== 1) begin
            errors++;
            $display("FAIL timeout_low count: got %0d reports, expected 1", ev_q.size() - first);
        end
        if (ev_q.size() > first) begin
            checks++;
            if (ev_q[first].v !== 1'b1 || ev_q[first].e !== 1'b0 || ev_q[first].duty !== 0) begin
                errors++;
                $display("FAIL timeout_low report: got valid=%b err=%b duty=%0d, expected valid=1 err=0 duty=0",
                         ev_q[first].v, ev_q[first].e, ev_q[first].duty);
            end
            checks++;
            if (ev_q[first].cyc - rel_cyc < 255 || ev_q[first].cyc - rel_cyc > 272) begin
                errors++;
                $display("FAIL timeout_low latency: got %0d cycles, expected 255..272", ev_q[first].cyc - rel_cyc);
            end
        end
    endtask

    task automatic test_duty8();
        do_reset(1'b0);
        fr_h = '{128, 128, 128};
        fr_p = '{256, 256, 256};
        play("duty8");
    endtask

    task automatic test_sequence();
        int seq[8] = '{8, 11, 4, 12, 10, 5, 9, 11};
        do_reset(1'b0);
        fr_h.delete();
        fr_p.delete();
        foreach (seq[i]) begin
            fr_h.push_back(seq[i] * T_SLOT);
            fr_p.push_back(T_PERIOD);
        end
        play("sequence");
    endtask

    task automatic test_random();
        int p;
        do_reset(1'b0);
        fr_h.delete();
        fr_p.delete();
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                p = ($urandom_range(0, 1) == 1) ? int'($urandom_range(240, 251)) : 261;
            end else begin
                p = int'($urandom_range(252, 260));
            end
            fr_p.push_back(p);
            fr_h.push_back(int'($urandom_range(3, p - 3)));
        end
        play("random");
    endtask

    task automatic test_period_err();
        do_reset(1'b0);
        fr_h = '{96, 120, 160, 120, 130};
        fr_p = '{256, 240, 258, 240, 261};
        play("period_err");
    endtask

    task automatic test_glitch();
        do_reset(1'b0);
`ifdef PWM_GLITCH_FILTER_EN
        fr_h = '{128, 128, 128};
        fr_p = '{256, 256, 256};
        glitch_at = 60;
        play("glitch_filtered");
        glitch_at = 0;
`else
        fr_h = '{128, 1, 128};
        fr_p = '{178, 78, 256};
        play("glitch_unfiltered");
`endif
    endtask

    task automatic test_stuck_high();
        int first;
        do_reset(1'b0);
        fr_h = '{80};
        fr_p = '{256};
        play("pre_stuck");
        first = ev_q.size();
        step(1'b1, 300);
        checks++;
        if (stuck_high !== 1'b1) begin errors++; $display("FAIL stuck_high set: got %b, expected 1", stuck_high); end
        checks++;
        if (stuck_rise_cyc - last_rise_cyc < 255 || stuck_rise_cyc - last_rise_cyc > 275) begin
            errors++;
            $display("FAIL stuck_high latency: got %0d cycles, expected 255..275", stuck_rise_cyc - last_rise_cyc);
        end
        checks++;
        if (duty_cycle !== 4'd5) begin errors++; $display("FAIL stuck_high duty hold: got %0d, expected 5", duty_cycle); end
        checks++;
        if (ev_q.size() !== first) begin
            errors++;
            $display("FAIL stuck_high reports: got %0d, expected 0", ev_q.size() - first);
        end
        step(1'b0, 10);
        checks++;
        if (stuck_high !== 1'b0) begin errors++; $display("FAIL stuck_high clear: got %b, expected 0", stuck_high); end
    endtask

    task automatic test_reset_mid();
        int first;
        int nvalid;
        int vduty;
        int vcyc;
        int second_rise;
        do_reset(1'b0);
        fr_h = '{128};
        fr_p = '{256};
        play("pre_reset_mid");
        step(1'b1, 50);
        reset = 1'b1;
        @(posedge clk_50M);
        #1;
        reset      = 1'b0;
        model_duty = 0;
        checks++;
        if ({duty_cycle, duty_valid, period_err, stuck_high} !== 7'd0) begin
            errors++;
            $display("FAIL reset_mid outputs: got duty=%0d valid=%b err=%b stuck=%b, expected all 0",
                     duty_cycle, duty_valid, period_err, stuck_high);
        end
        first = ev_q.size();
        step(1'b1, 68);
        step(1'b0, 128);
        step(1'b1, 128);
        step(1'b0, 128);
        step(1'b1, 10);
        second_rise = last_rise_cyc;
        nvalid = 0;
        vduty  = -1;
        vcyc   = -1;
        for (int i = first; i < ev_q.size(); i++) begin
            if (ev_q[i].v) begin
                nvalid++;
                vduty = ev_q[i].duty;
                vcyc  = ev_q[i].cyc;
            end
        end
        checks++;
        if (nvalid !== 1) begin errors++; $display("FAIL reset_mid valid count: got %0d, expected 1", nvalid); end
        checks++;
        if (vduty !== 8) begin errors++; $display("FAIL reset_mid duty: got %0d, expected 8", vduty); end
        checks++;
        if (vcyc <= second_rise) begin
            errors++;
            $display("FAIL reset_mid report timing: got cycle %0d, expected after second rise at %0d", vcyc, second_rise);
        end
    endtask

    initial begin
        test_reset();
        test_timeout_low();
        test_duty8();
        test_sequence();
        test_random();
        test_period_err();
        test_glitch();
        test_stuck_high();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
